cache_ctrl_fsm: RTL and testbench
=================================

Name: cache_ctrl_fsm

Overview:
Parametrised, sequential direct-mapped cache controller that sits between the pipeline's memory stage and main memory. It generalises the step-4 cache control logic to any number of sets and words per line. It owns its tag, valid and data arrays. It adds a request/response handshake, multi-beat line refill from memory, write-through stores, a flush command and hit/miss statistics counters.

Parameters:
WIDTH, 32, data word width in bits
ADDR_W, 5, word address width; memory holds 2^ADDR_W words
SETS, 2, number of cache lines; power of two, >=2; IDX_W = log2(SETS)
WORDS, 4, words per line; power of two, >=2; OFF_W = log2(WORDS)
CNT_W, 16, width of the statistics counters
Derived: TAG_W = ADDR_W - IDX_W - OFF_W, must be >=1

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  pipeline request present
req_ready  out  1  controller accepts a request this cycle
req_write  in  1  1 = store (sw, opcode 6'b101011), 0 = load
req_addr  in  ADDR_W  word address, split as {tag, index, offset}
req_wdata  in  WIDTH  store data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  WIDTH  load data, valid while resp_valid=1
resp_hit  out  1  1 if the completed access hit
flush  in  1  invalidate all lines
mem_req  out  1  memory transaction request
mem_we  out  1  1 = memory write
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  WIDTH  memory write data
mem_ack  in  1  memory completes the current beat this cycle
mem_rdata  in  WIDTH  read data, valid when mem_ack=1
hit_count  out  CNT_W  saturating count of hits
miss_count  out  CNT_W  saturating count of misses

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all valid bits clear.
  - Counters go to 0; all outputs go to 0 immediately, except req_ready, which becomes 1 once rst=1.
  - The data and tag arrays are not reset.
  - If reset arrives mid-transaction, it aborts the transaction: mem_req drops the same cycle and the pending response is discarded.
- States: IDLE, CHECK, REFILL, WRITE, RESP.
- IDLE:
  - req_ready = !flush.
  - If flush=1, all valid bits clear at the edge and any request in that cycle is not accepted.
  - Otherwise, on req_valid & req_ready, latch write/addr/wdata and go to CHECK.
  - A flush in any other state is ignored.
- CHECK:
  - hit = valid[index] & (tag_array[index] == tag).
  - Load hit: hit_count increments and the state goes to RESP.
  - Load miss: miss_count increments, the beat counter is set to 0 and the state goes to REFILL.
  - Store (hit or miss): the matching counter increments. On a hit the addressed word in the data array is written with wdata. The state goes to WRITE.
  - No allocation on a store miss.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, beat}.
  - On each mem_ack, data[index][beat] = mem_rdata and beat increments.
  - On the ack for beat WORDS-1: tag_array[index] = tag, valid[index] = 1, and the state goes to RESP.
  - resp_rdata returns the requested offset's word from the refilled line.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = latched addr, mem_wdata = latched wdata.
  - On mem_ack, go to RESP. Write-through: memory is always updated.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata = data[index][offset] for loads; 0 for stores.
  - resp_hit = the hit result from CHECK. Then go to IDLE.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata hold stable while mem_req=1 and no ack has arrived.
  - mem_ack with mem_req=0 is ignored.
  - mem_req deasserts in the cycle after the final ack.
  - An unbounded ack delay is legal.
- Latency from acceptance edge T:
  - Load hit: resp_valid in cycle T+2.
  - Load miss: T+2+(sum of beat latencies).
  - Store: T+2+(write latency).
- Only one request is outstanding at a time; req_ready=0 outside IDLE.
- Counters saturate at 2^CNT_W-1 with no wrap.

Test Plan:
1. Reset, then load addr 5 (index 1, offset 1), memory returns word = addr+100 with ack after 1 cycle -> 4 beats to addr 4..7, resp_rdata=105, resp_hit=0, miss_count=1.
2. Repeat load addr 6 immediately -> no mem_req, resp_valid exactly 2 cycles after acceptance, rdata=106, resp_hit=1, hit_count=1.
3. Store addr 6 data 0xDEAD (hit) -> single mem write addr 6 data 0xDEAD; a later load of addr 6 returns 0xDEAD with resp_hit=1. Store to uncached addr 20 -> mem write only; a later load of 20 misses.
4. Assert flush in IDLE together with req_valid -> request not accepted (req_ready=0); a load of addr 5 afterwards misses and refills.
5. Drop rst mid-REFILL after beat 1 -> mem_req=0 immediately, no resp_valid, counters=0, and a load of addr 5 after reset misses.
6. Force hit_count to 2^CNT_W-1 (small CNT_W=2 build) and perform further hits -> count stays at 3.

Source files
------------

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// One request is outstanding at a time. A load miss refills the whole line
// from memory one beat at a time. Every store is also written to memory.
//
// Handshakes:
//   req:  a request transfers on a rising edge where req_valid && req_ready.
//         req_ready is high only in IDLE, while flush is low and reset is
//         released.
//   resp: resp_valid is a one-cycle pulse. resp_rdata and resp_hit are
//         meaningful only while it is high.
//   mem:  mem_req/mem_we/mem_addr/mem_wdata hold stable until a cycle with
//         mem_ack=1 completes the beat. mem_ack is ignored while mem_req=0.
module cache_ctrl_fsm #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int SETS   = 2,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              resp_valid,
    output logic [WIDTH-1:0]  resp_rdata,
    output logic              resp_hit,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [2:0]        fsm_state
);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {IDLE, CHECK, REFILL, WRITE, RESP} state_t;

    state_t state;
    state_t next_state;

    // Request fields captured at acceptance.
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [WIDTH-1:0]  lat_wdata;
    logic              hit_r;
    logic [OFF_W-1:0]  beat;

    // Cache storage. Only the valid bits are reset.
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_arr  [SETS];
    logic [WIDTH-1:0]  data_arr [SETS][WORDS];

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              hit;
    logic              accept;

    assign {tag, idx, off} = lat_addr;
    assign hit       = valid[idx] && (tag_arr[idx] == tag);
    assign accept    = (state == IDLE) && req_valid && req_ready;
    assign fsm_state = state;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore outputs for every state.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_hit   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = rst && !flush;
                if (req_valid && req_ready) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (lat_write) begin
                    next_state = WRITE;
                end else if (hit) begin
                    next_state = RESP;
                end else begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag, idx, beat};
                if (mem_ack && (&beat)) begin
                    next_state = RESP;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                if (mem_ack) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_r;
                resp_rdata = lat_write ? '0 : data_arr[idx][off];
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture, valid bits, beat counter and saturating statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            hit_r      <= 1'b0;
            beat       <= '0;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && flush) begin
                valid <= '0;
            end
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (state == CHECK) begin
                hit_r <= hit;
                beat  <= '0;
                if (hit) begin
                    if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                end else begin
                    if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                end
            end
            if (state == REFILL && mem_ack) begin
                beat <= beat + OFF_W'(1);
                if (&beat) begin
                    valid[idx] <= 1'b1;
                end
            end
        end
    end

    // Data and tag arrays: store-hit update and line refill.
    always_ff @(posedge clk) begin
        if (state == CHECK && lat_write && hit) begin
            data_arr[idx][off] <= lat_wdata;
        end
        if (state == REFILL && mem_ack) begin
            data_arr[idx][beat] <= mem_rdata;
            if (&beat) begin
                tag_arr[idx] <= tag;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm. Memory is a behavioural model:
// word n holds n+100 at start, and each beat is acked one cycle after it is
// requested. Counters are built 2 bits wide so saturation is reachable.
module tb_cache_ctrl_fsm;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              resp_valid;
    logic [WIDTH-1:0]  resp_rdata;
    logic              resp_hit;
    logic              flush;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_ack;
    logic [WIDTH-1:0]  mem_rdata;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;
    logic [2:0]        fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0]  mem_model [32];
    logic [ADDR_W-1:0] rd_addr_q [$];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [WIDTH-1:0]  wr_data_q [$];
    int                rd_count = 0;
    int                mem_req_cycles = 0;
    int                wait_cnt = 0;

    cache_ctrl_fsm #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETS(2), .WORDS(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count), .fsm_state(fsm_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: one idle cycle, then a one-cycle ack per beat.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 32; i++) mem_model[i] = 32'(i + 100);
        forever begin
            @(negedge clk);
            if (mem_ack) mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                mem_req_cycles++;
                if (wait_cnt < 1) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    if (mem_we) begin
                        mem_model[mem_addr] = mem_wdata;
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                    end else begin
                        mem_rdata = mem_model[mem_addr];
                        rd_addr_q.push_back(mem_addr);
                        rd_count++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // Driver: issue one request and wait (bounded) for its response.
    // cyc counts negedges after the acceptance edge until resp_valid.
    task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [WIDTH-1:0] wd, output logic [WIDTH-1:0] rd,
                          output logic h, output int cyc);
        bit got;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_ready_accept addr=%0d: got %b want 1", a, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        cyc = 0;
        rd  = '0;
        h   = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                rd  = resp_rdata;
                h   = resp_hit;
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL resp_timeout addr=%0d: no resp_valid within 200 cycles", a);
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL resp_one_cycle addr=%0d: resp_valid still %b", a, resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b mem_req=%b resp_valid=%b want 0 0 0",
                     req_ready, mem_req, resp_valid);
        end
        n_cmp++;
        if (hit_count !== 2'd0 || miss_count !== 2'd0) begin
            n_err++;
            $display("FAIL reset_counters: hit=%0d miss=%0d want 0 0", hit_count, miss_count);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_load_miss();
        logic [WIDTH-1:0] rd; logic h; int cyc;
        rd_addr_q.delete();
        do_req(1'b0, 5'd5, '0, rd, h, cyc);
        n_cmp++;
        if (rd !== 32'd105 || h !== 1'b0) begin
            n_err++;
            $display("FAIL load_miss_resp: rdata=%0d hit=%b want 105 0", rd, h);
        end
        n_cmp++;
        if (cyc !== 10) begin
            n_err++;
            $display("FAIL load_miss_latency: got %0d want 10", cyc);
        end
        n_cmp++;
        if (miss_count !== 2'd1 || hit_count !== 2'd0) begin
            n_err++;
            $display("FAIL load_miss_counts: hit=%0d miss=%0d want 0 1", hit_count, miss_count);
        end
        n_cmp++;
        if (rd_addr_q.size() != 4) begin
            n_err++;
            $display("FAIL refill_beats: got %0d reads want 4", rd_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_addr_q[i] !== 5'(4 + i)) begin
                    n_err++;
                    $display("FAIL refill_addr beat %0d: got %0d want %0d", i, rd_addr_q[i], 4 + i);
                end
            end
        end
    endtask

    task automatic test_load_hit();
        logic [WIDTH-1:0] rd; logic h; int cyc; int base;
        base = mem_req_cycles;
        do_req(1'b0, 5'd6, '0, rd, h, cyc);
        n_cmp++;
        if (rd !== 32'd106 || h !== 1'b1) begin
            n_err++;
            $display("FAIL load_hit_resp: rdata=%0d hit=%b want 106 1", rd, h);
        end
        n_cmp++;
        if (cyc !== 2) begin
            n_err++;
            $display("FAIL load_hit_latency: got %0d want 2", cyc);
        end
        n_cmp++;
        if (mem_req_cycles != base) begin
            n_err++;
            $display("FAIL load_hit_no_mem: got %0d mem_req cycles want 0", mem_req_cycles - base);
        end
        n_cmp++;
        if (hit_count !== 2'd1 || miss_count !== 2'd1) begin
            n_err++;
            $display("FAIL load_hit_counts: hit=%0d miss=%0d want 1 1", hit_count, miss_count);
        end
    endtask

    task automatic test_store();
        logic [WIDTH-1:0] rd; logic h; int cyc;
        // Store hit: write-through of one word, cache updated.
        wr_addr_q.delete(); wr_data_q.delete();
        do_req(1'b1, 5'd6, 32'hDEAD, rd, h, cyc);
        n_cmp++;
        if (rd !== 32'd0 || h !== 1'b1 || cyc !== 4) begin
            n_err++;
            $display("FAIL store_hit_resp: rdata=%0h hit=%b cyc=%0d want 0 1 4", rd, h, cyc);
        end
        n_cmp++;
        if (wr_addr_q.size() != 1) begin
            n_err++;
            $display("FAIL store_hit_writes: got %0d writes want 1", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 5'd6 || wr_data_q[0] !== 32'hDEAD) begin
            n_err++;
            $display("FAIL store_hit_mem: addr=%0d data=%0h want 6 dead", wr_addr_q[0], wr_data_q[0]);
        end
        n_cmp++;
        if (hit_count !== 2'd2) begin
            n_err++;
            $display("FAIL store_hit_count: got %0d want 2", hit_count);
        end
        do_req(1'b0, 5'd6, '0, rd, h, cyc);
        n_cmp++;
        if (rd !== 32'hDEAD || h !== 1'b1) begin
            n_err++;
            $display("FAIL load_after_store: rdata=%0h hit=%b want dead 1", rd, h);
        end
        // Store miss: memory only, no allocation.
        wr_addr_q.delete(); wr_data_q.delete();
        do_req(1'b1, 5'd20, 32'h1234, rd, h, cyc);
        n_cmp++;
        if (h !== 1'b0 || wr_addr_q.size() != 1) begin
            n_err++;
            $display("FAIL store_miss: hit=%b writes=%0d want 0 1", h, wr_addr_q.size());
        end else if (wr_addr_q[0] !== 5'd20 || wr_data_q[0] !== 32'h1234) begin
            n_err++;
            $display("FAIL store_miss_mem: addr=%0d data=%0h want 20 1234", wr_addr_q[0], wr_data_q[0]);
        end
        n_cmp++;
        if (hit_count !== 2'd3 || miss_count !== 2'd2) begin
            n_err++;
            $display("FAIL store_counts: hit=%0d miss=%0d want 3 2", hit_count, miss_count);
        end
        do_req(1'b0, 5'd20, '0, rd, h, cyc);
        n_cmp++;
        if (rd !== 32'h1234 || h !== 1'b0 || cyc !== 10) begin
            n_err++;
            $display("FAIL load_after_store_miss: rdata=%0h hit=%b cyc=%0d want 1234 0 10", rd, h, cyc);
        end
        n_cmp++;
        if (miss_count !== 2'd3) begin
            n_err++;
            $display("FAIL miss_count_3: got %0d want 3", miss_count);
        end
    endtask

    task automatic test_flush();
        logic [WIDTH-1:0] rd; logic h; int cyc; int seen; int base;
        do_req(1'b0, 5'd5, '0, rd, h, cyc);
        do_req(1'b0, 5'd5, '0, rd, h, cyc);
        n_cmp++;
        if (rd !== 32'd105 || h !== 1'b1) begin
            n_err++;
            $display("FAIL pre_flush_hit: rdata=%0d hit=%b want 105 1", rd, h);
        end
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready: got %b want 0", req_ready);
        end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL flush_no_accept: got %0d busy cycles want 0", seen);
        end
        base = rd_count;
        do_req(1'b0, 5'd5, '0, rd, h, cyc);
        n_cmp++;
        if (rd !== 32'd105 || h !== 1'b0 || rd_count - base != 4) begin
            n_err++;
            $display("FAIL post_flush_miss: rdata=%0d hit=%b reads=%0d want 105 0 4",
                     rd, h, rd_count - base);
        end
    endtask

    task automatic test_reset_abort();
        logic [WIDTH-1:0] rd; logic h; int cyc; int base; int guard; int seen;
        base = rd_count;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd13;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        guard = 0;
        while (rd_count < base + 2 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 100) begin
            n_err++;
            $display("FAIL abort_wait: refill beats got %0d want 2", rd_count - base);
        end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: mem_req=%b resp_valid=%b ready=%b want 0 0 0",
                     mem_req, resp_valid, req_ready);
        end
        n_cmp++;
        if (hit_count !== 2'd0 || miss_count !== 2'd0) begin
            n_err++;
            $display("FAIL abort_counters: hit=%0d miss=%0d want 0 0", hit_count, miss_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_discard: got %0d busy cycles want 0", seen);
        end
        do_req(1'b0, 5'd5, '0, rd, h, cyc);
        n_cmp++;
        if (rd !== 32'd105 || h !== 1'b0 || miss_count !== 2'd1) begin
            n_err++;
            $display("FAIL post_reset_miss: rdata=%0d hit=%b miss=%0d want 105 0 1", rd, h, miss_count);
        end
    endtask

    task automatic test_saturate();
        logic [WIDTH-1:0] rd; logic h; int cyc;
        logic [CNT_W-1:0] exp_h [4];
        exp_h = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 5'd5, '0, rd, h, cyc);
            n_cmp++;
            if (hit_count !== exp_h[i] || h !== 1'b1) begin
                n_err++;
                $display("FAIL hit_saturate step %0d: count=%0d hit=%b want %0d 1",
                         i, hit_count, h, exp_h[i]);
            end
        end
        n_cmp++;
        if (miss_count !== 2'd1) begin
            n_err++;
            $display("FAIL saturate_miss_unchanged: got %0d want 1", miss_count);
        end
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store();
        test_flush();
        test_reset_abort();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
